// File: rtl/ifu_pc_gen_if.sv
// Fetch-side bundle between the decode/control logic and the PC unit.
// All fields are level signals that hold for one clock. There is no
// valid/ready pairing:
//   - redirect fields (stall, br_*, jmp*, jr*) are sampled on every rising
//     edge;
//   - pc-side outputs are valid for the whole cycle that follows the edge.
interface ifu_pc_gen_if;
   logic        stall;
   logic        br_taken;
   logic [15:0] br_imm16;
   logic        jmp;
   logic [25:0] jmp_idx26;
   logic        jr;
   logic [31:0] jr_target;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] link_addr;
   logic        addr_err;
   logic [31:0] fetch_cnt;

   // Control side: drives redirects, observes the PC.
   modport master (
      output stall, br_taken, br_imm16, jmp, jmp_idx26, jr, jr_target,
      input  pc, pc_plus4, link_addr, addr_err, fetch_cnt
   );

   // PC unit side.
   modport slave (
      input  stall, br_taken, br_imm16, jmp, jmp_idx26, jr, jr_target,
      output pc, pc_plus4, link_addr, addr_err, fetch_cnt
   );
endinterface

// File: rtl/ifu_pc_gen.sv
// Program-counter generator for the single-cycle MIPS fetch stage.
// Picks the next PC among jr / j / branch / sequential, checks it against the
// instruction-memory window and either advances or freezes with a sticky error.
module ifu_pc_gen #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned IM_WORDS = 1024
) (
   input  logic          clk,
   input  logic          reset,
   ifu_pc_gen_if.slave   bus
);

   // Window bounds kept in 33 bits so a window ending at 2^32 and a
   // wrapped candidate cannot alias into a legal address.
   localparam logic [32:0] WIN_LO = {1'b0, RESET_PC};
   localparam logic [32:0] WIN_HI = WIN_LO + (33'(IM_WORDS) << 2);

   logic [31:0] pc_q;
   logic [31:0] cnt_q;
   logic        err_q;

   logic [31:0] pc_plus4;
   logic [31:0] br_off;
   logic [31:0] br_target;
   logic [31:0] jmp_target;
   logic [31:0] cand;
   logic [32:0] cand_wide;
   logic        cand_legal;
   logic        advance;
   logic        raise_err;

   // Sequential successor and the two pc-relative redirect targets.
   always_comb begin
      pc_plus4   = pc_q + 32'd4;
      br_off     = {{14{bus.br_imm16[15]}}, bus.br_imm16, 2'b00};
      br_target  = pc_plus4 + br_off;
      jmp_target = {pc_plus4[31:28], bus.jmp_idx26, 2'b00};
   end

   // Fixed-priority selection of the next-PC candidate: jr > j > branch > seq.
   always_comb begin
      cand = pc_plus4;
      if (bus.jr)
         cand = bus.jr_target;
      else if (bus.jmp)
         cand = jmp_target;
      else if (bus.br_taken)
         cand = br_target;
   end

   // Candidate must be word aligned and inside [WIN_LO, WIN_HI).
   always_comb begin
      cand_wide  = {1'b0, cand};
      cand_legal = (cand[1:0] == 2'b00) && (cand_wide >= WIN_LO) && (cand_wide < WIN_HI);
   end

   // Edge decision: frozen on error, then stall, then legality.
   always_comb begin
      advance   = !err_q && !bus.stall && cand_legal;
      raise_err = !err_q && !bus.stall && !cand_legal;
   end

   // PC and fetch counter move together only on a legal, unstalled advance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q  <= RESET_PC;
         cnt_q <= 32'd0;
      end else if (advance) begin
         pc_q  <= cand;
         cnt_q <= cnt_q + 32'd1;
      end
   end

   // Sticky fetch-address error; only reset clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         err_q <= 1'b0;
      else if (raise_err)
         err_q <= 1'b1;
   end

   assign bus.pc        = pc_q;
   assign bus.pc_plus4  = pc_plus4;
   assign bus.link_addr = pc_plus4;
   assign bus.addr_err  = err_q;
   assign bus.fetch_cnt = cnt_q;

endmodule
